frame_tx_1101: RTL and testbench
================================

Name: frame_tx_1101

Overview:
- Serial frame transmitter: the sending end of the 1101 sequence-detection link.
- Accepts a parallel data word via a start/ready handshake. Emits on a single serial line a 4-bit preamble (default 1101), then the data word MSB first, then idle gap cycles.
- Output drives the serial input of the existing 1101 detector, which locks on at the preamble end.
- Registered outputs throughout (Moore style).

Parameters:
- DATA_W, 8: payload width in bits; legal range 1..32.
- PATTERN, 4'b1101: preamble, transmitted MSB first.
- GAP_CYC, 1: idle-low cycles after the last data bit; legal range 1..15.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; sampled on posedge clk.
- start  input  1  request to send; accepted only when ready=1.
- data  input  DATA_W  payload; captured on the accepting edge.
- ready  output  1  high only in IDLE; combinational from state.
- y  output  1  registered serial line; idle level 0.
- busy  output  1  registered; high from the accepting edge until return to IDLE.
- done  output  1  registered one-cycle pulse on the first IDLE cycle after a completed frame.

Behaviour:
- Reset: at any posedge with reset=0:
  - state=IDLE, y=0, busy=0, done=0, counters and shift register cleared.
  - ready=1 from the following cycle.
  - reset has priority over all other inputs.
- States: IDLE, PRE, DATA, GAP; encodings are held in the shared header.
- IDLE:
  - y=0, busy=0.
  - On an edge with start=1: latch data into the shift register, cnt=0, y=PATTERN[3], busy=1, go to PRE.
- PRE:
  - Each edge: cnt++ and y=PATTERN[3-cnt].
  - After 4 preamble bits, load y=data MSB, cnt=0, go to DATA.
- DATA:
  - Each edge: shift left; y=next bit.
  - After DATA_W bits: y=0, cnt=0, go to GAP.
- GAP:
  - y=0 for GAP_CYC cycles.
  - Then go to IDLE, busy=0, done=1 for exactly one cycle.
- Timing, with the accepting edge k:
  - Preamble is visible on y after edges k..k+3.
  - Data bit i (MSB=0) is visible after edge k+4+i.
  - Gap is visible after edges k+4+DATA_W .. k+3+DATA_W+GAP_CYC.
  - IDLE and done are seen after edge k+4+DATA_W+GAP_CYC.
- Minimum accept-to-accept period: 5+DATA_W+GAP_CYC cycles (14 at defaults).
- start while busy: ignored; data is not re-latched; no queuing.
- start held high continuously: frames go back-to-back at the minimum period, each latching data at its accept edge.
- data changes mid-frame: no effect on the frame in flight.
- Reset mid-frame: abort immediately; y=0 on the reset edge; no done pulse.
- Counter width: ceil(log2(max(DATA_W,4,GAP_CYC)))+1. No wrap-around is possible within legal parameters.

Decomposition:
- Shared header seq1101_defs.vh holds:
  - state encodings (IDLE=2'b00, PRE=2'b01, DATA=2'b11, GAP=2'b10);
  - the default PATTERN 4'b1101;
  - FOUND/NOTFOUND constants shared with the detector.
- One natural sub-module: piso_shift.
  - Interface: DATA_W-bit parallel-in/serial-out register with load and shift enables, MSB out.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 -> y=0, busy=0, done=0, ready=1 after release; no frame starts until start is sampled with reset=1.
- Single frame: data=8'hA5, start pulse at edge k -> y after edges k..k+12 = 1,1,0,1,1,0,1,0,0,1,0,1,0; done=1 only after edge k+13; busy=1 from k to k+12.
- Back-to-back: start held high with data=8'hFF then 8'h00 -> second accept exactly 14 cycles after the first; y shows 1101 11111111 0 then 1101 00000000 0.
- Busy ignore: start pulses with data=8'h3C at cycles k+2 and k+7 during a frame carrying 8'hA5 -> the frame is unchanged; no second frame; ready=0 throughout.
- Reset mid-frame: reset=0 at edge k+6 -> y=0 and busy=0 after that edge; done never pulses; a new start afterwards yields a clean full frame.
- Loopback: y drives the 1101 detector's serial input with data=8'h00 -> detector flags found exactly once, at the preamble's final 1 bit (edge k+3), and never during payload or gap.

Source files
------------

// File: rtl/frame_tx_1101_pkg.sv
// frame_tx_1101_pkg: state encodings and link constants shared by the 1101 transmitter and detector
package frame_tx_1101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        DATA = 2'b11,
        GAP  = 2'b10
    } state_t;

    localparam logic [3:0] PATTERN_1101 = 4'b1101;
    localparam logic       FOUND        = 1'b1;
    localparam logic       NOTFOUND     = 1'b0;

    // Counter must reach the longest phase: preamble, payload or gap.
    function automatic int cnt_w(input int data_w, input int gap_cyc);
        int m;
        m = data_w > 4 ? data_w : 4;
        m = gap_cyc > m ? gap_cyc : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/frame_tx_1101_piso_shift.sv
// piso_shift: parallel-in/serial-out register, MSB first, with load and shift enables
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!reset)
            sr <= '0;
        else if (load)
            sr <= d;
        else if (shift)
            sr <= sr << 1;
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/frame_tx_1101.sv
// frame_tx_1101: serial frame transmitter sending preamble, MSB-first payload and idle gap
module frame_tx_1101
    import frame_tx_1101_pkg::*;
#(
    parameter int         DATA_W  = 8,
    parameter logic [3:0] PATTERN = PATTERN_1101,
    parameter int         GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              y,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_w(DATA_W, GAP_CYC);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            y_n, busy_n, done_n;
    logic            load, shift, msb;

    piso_shift #(.DATA_W(DATA_W)) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (data),
        .msb   (msb)
    );

    assign ready = state == IDLE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    y_n     = PATTERN[3];
                    busy_n  = 1'b1;
                    state_n = PRE;
                end
            end
            PRE: begin
                // The last preamble edge already presents the payload MSB.
                if (cnt == CW'(3)) begin
                    y_n     = msb;
                    shift   = 1'b1;
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    y_n   = PATTERN[2'd2 - cnt[1:0]];
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CW'(DATA_W - 1)) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    y_n   = msb;
                    shift = 1'b1;
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            y     <= y_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_frame_tx_1101.sv
// tb_frame_tx_1101: directed self-checking bench for the 1101 frame transmitter
module tb_frame_tx_1101;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data;
    logic       ready, y, busy, done;
    int         tests = 0;
    int         fails = 0;

    frame_tx_1101 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .ready (ready),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            tests += 4;
            if (y !== 1'b0)    begin fails++; $display("FAIL reset_y[%0d]: got %b want 0", i, y); end
            if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy); end
            if (done !== 1'b0) begin fails++; $display("FAIL reset_done[%0d]: got %b want 0", i, done); end
            if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready[%0d]: got %b want 1", i, ready); end
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        tests += 3;
        if (y !== 1'b0)     begin fails++; $display("FAIL release_y: got %b want 0", y); end
        if (busy !== 1'b0)  begin fails++; $display("FAIL release_busy: got %b want 0", busy); end
        if (ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", ready); end
    endtask

    task automatic test_single_frame;
        logic [12:0] e;
        e = 13'b1101_10100101_0;
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        data  = 8'h00;
        for (int j = 0; j < 13; j++) begin
            if (j > 0) step();
            tests += 4;
            if (y !== e[12-j])  begin fails++; $display("FAIL single_y[k+%0d]: got %b want %b", j, y, e[12-j]); end
            if (busy !== 1'b1)  begin fails++; $display("FAIL single_busy[k+%0d]: got %b want 1", j, busy); end
            if (done !== 1'b0)  begin fails++; $display("FAIL single_done[k+%0d]: got %b want 0", j, done); end
            if (ready !== 1'b0) begin fails++; $display("FAIL single_ready[k+%0d]: got %b want 0", j, ready); end
        end
        step();
        tests += 4;
        if (done !== 1'b1)  begin fails++; $display("FAIL single_done_end: got %b want 1", done); end
        if (busy !== 1'b0)  begin fails++; $display("FAIL single_busy_end: got %b want 0", busy); end
        if (y !== 1'b0)     begin fails++; $display("FAIL single_y_end: got %b want 0", y); end
        if (ready !== 1'b1) begin fails++; $display("FAIL single_ready_end: got %b want 1", ready); end
        step();
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        logic [12:0] e1, e2;
        e1 = 13'b1101_11111111_0;
        e2 = 13'b1101_00000000_0;
        start = 1'b1;
        data  = 8'hFF;
        step();
        data = 8'h00;
        for (int j = 0; j < 13; j++) begin
            if (j > 0) step();
            tests += 2;
            if (y !== e1[12-j]) begin fails++; $display("FAIL b2b1_y[k+%0d]: got %b want %b", j, y, e1[12-j]); end
            if (ready !== 1'b0) begin fails++; $display("FAIL b2b1_ready[k+%0d]: got %b want 0", j, ready); end
        end
        step();
        tests += 3;
        if (done !== 1'b1)  begin fails++; $display("FAIL b2b_done1: got %b want 1", done); end
        if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_gap: got %b want 1", ready); end
        if (y !== 1'b0)     begin fails++; $display("FAIL b2b_y_idle: got %b want 0", y); end
        step();
        start = 1'b0;
        tests += 3;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept14_busy: got %b want 1", busy); end
        if (y !== 1'b1)    begin fails++; $display("FAIL b2b_accept14_y: got %b want 1", y); end
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_accept14_done: got %b want 0", done); end
        for (int j = 1; j < 13; j++) begin
            step();
            tests++;
            if (y !== e2[12-j]) begin fails++; $display("FAIL b2b2_y[k+%0d]: got %b want %b", j, y, e2[12-j]); end
        end
        step();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL b2b_done2: got %b want 1", done); end
        step();
    endtask

    task automatic test_busy_ignore;
        logic [12:0] e;
        e = 13'b1101_10100101_0;
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        for (int j = 1; j < 13; j++) begin
            start = (j == 2 || j == 7);
            data  = (j == 2 || j == 7) ? 8'h3C : 8'hA5;
            step();
            tests += 2;
            if (y !== e[12-j])  begin fails++; $display("FAIL ignore_y[k+%0d]: got %b want %b", j, y, e[12-j]); end
            if (ready !== 1'b0) begin fails++; $display("FAIL ignore_ready[k+%0d]: got %b want 0", j, ready); end
        end
        start = 1'b0;
        step();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL ignore_done: got %b want 1", done); end
        for (int j = 0; j < 3; j++) begin
            step();
            tests += 2;
            if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_frame_busy[%0d]: got %b want 0", j, busy); end
            if (y !== 1'b0)    begin fails++; $display("FAIL ignore_no_frame_y[%0d]: got %b want 0", j, y); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [12:0] e;
        e = 13'b1101_01011010_0;
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        for (int j = 1; j < 6; j++) step();
        reset = 1'b0;
        step();
        tests += 4;
        if (y !== 1'b0)     begin fails++; $display("FAIL abort_y: got %b want 0", y); end
        if (busy !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0)  begin fails++; $display("FAIL abort_done: got %b want 0", done); end
        if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", ready); end
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            tests += 2;
            if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done[%0d]: got %b want 0", j, done); end
            if (busy !== 1'b0) begin fails++; $display("FAIL abort_idle_busy[%0d]: got %b want 0", j, busy); end
        end
        start = 1'b1;
        data  = 8'h5A;
        step();
        start = 1'b0;
        for (int j = 0; j < 13; j++) begin
            if (j > 0) step();
            tests++;
            if (y !== e[12-j]) begin fails++; $display("FAIL reframe_y[k+%0d]: got %b want %b", j, y, e[12-j]); end
        end
        step();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL reframe_done: got %b want 1", done); end
    endtask

    task automatic test_loopback;
        logic [3:0] hist;
        int         found, at;
        hist  = 4'b0000;
        found = 0;
        at    = -1;
        start = 1'b1;
        data  = 8'h00;
        step();
        start = 1'b0;
        for (int j = 0; j < 15; j++) begin
            if (j > 0) step();
            hist = {hist[2:0], y};
            if (hist == 4'b1101) begin
                found++;
                at = j;
            end
        end
        tests += 2;
        if (found != 1) begin fails++; $display("FAIL loop_found_count: got %0d want 1", found); end
        if (at != 3)    begin fails++; $display("FAIL loop_found_edge: got k+%0d want k+3", at); end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
